// File: rtl/norm_result_collector_pkg.sv
// Shared definitions for the L2-norm result collector: FSM encodings and batch geometry.
package norm_result_collector_pkg;

  localparam int NRC_NUM_BATCHES = 6;
  localparam int NRC_IDX_W       = 3;

  typedef enum logic {
    NRC_S_COLLECT = 1'b0,
    NRC_S_DONE    = 1'b1
  } nrc_state_t;

endpackage

// File: rtl/norm_result_fifo.sv
// Registered output queue for captured results; flush empties it in one cycle.
module norm_result_fifo #(
  parameter int DW    = 35,
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == (PW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/norm_result_collector.sv
// Drains per-batch results from the L2-norm accelerator into an MMIO queue and
// tracks running max/min/sum plus a done flag once every batch is captured.
module norm_result_collector
  import norm_result_collector_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_BATCHES = NRC_NUM_BATCHES,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [2*WIDTH-1:0]   rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [NRC_IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0]     max_val,
  output logic [WIDTH-1:0]     min_val,
  output logic [NRC_IDX_W-1:0] max_idx,
  output logic [NRC_IDX_W-1:0] min_idx,
  output logic [WIDTH+2:0]     sum_val,
  output logic [NRC_IDX_W-1:0] count,
  output logic                 done,
  output logic                 err_hi
);

  localparam logic [NRC_IDX_W-1:0] LAST = NRC_IDX_W'(NUM_BATCHES);

  nrc_state_t                 state;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       capture;
  logic                       pop;
  logic [WIDTH-1:0]           cap_val;
  logic [NRC_IDX_W-1:0]       count_next;
  logic [WIDTH+NRC_IDX_W-1:0] fifo_head;

  assign up_ready   = (state == NRC_S_COLLECT) && !fifo_full;
  assign capture    = up_valid && up_ready && !clear;
  assign pop        = out_valid && out_ready && !clear;
  assign cap_val    = rd_data[WIDTH-1:0];
  assign count_next = count + 1'b1;
  assign rd_addr    = ADDR_W'(count);

  norm_result_fifo #(
    .DW    (WIDTH + NRC_IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (clear),
    .push    (capture),
    .pop     (pop),
    .wr_data ({count, cap_val}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[WIDTH-1:0];
  assign out_idx   = fifo_head[WIDTH+NRC_IDX_W-1:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= NRC_S_COLLECT;
      count   <= '0;
      done    <= 1'b0;
      err_hi  <= 1'b0;
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      min_idx <= '0;
      sum_val <= '0;
    end else if (clear) begin
      state   <= NRC_S_COLLECT;
      count   <= '0;
      done    <= 1'b0;
      err_hi  <= 1'b0;
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      min_idx <= '0;
      sum_val <= '0;
    end else if (capture) begin
      count   <= count_next;
      sum_val <= sum_val + (WIDTH+3)'(cap_val);
      if (|rd_data[2*WIDTH-1:WIDTH]) err_hi <= 1'b1;
      // Strict compares keep the earliest index on ties.
      if (count == '0) begin
        max_val <= cap_val;
        min_val <= cap_val;
        max_idx <= '0;
        min_idx <= '0;
      end else begin
        if (cap_val > max_val) begin
          max_val <= cap_val;
          max_idx <= count;
        end
        if (cap_val < min_val) begin
          min_val <= cap_val;
          min_idx <= count;
        end
      end
      if (count_next == LAST) begin
        state <= NRC_S_DONE;
        done  <= 1'b1;
      end
    end
  end

endmodule
